// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction fetch path.
//   CPU_NOP_INSTR  : canonical RISC-V NOP (addi x0, x0, 0), returned on any fetch error
//   AXI_RESP_OKAY  : AXI read response code for a successful transfer
//   fetch_state_e  : instruction fetch FSM state encoding
//   is_word_aligned: true when a byte address is 32-bit aligned
package cpu_pkg;

  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    FETCH_IDLE     = 3'd0,
    FETCH_ADDR     = 3'd1,
    FETCH_DATA     = 3'd2,
    FETCH_DONE     = 3'd3,
    FETCH_WAIT_LOW = 3'd4
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: turns a level fetch request from the control unit
// into a single AXI read (AR + R channels) and returns the instruction word.
// Misaligned addresses, error responses and bus timeouts all return NOP_INSTR
// with fetch_error set.
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   fetch_en, fetch_address    : level request (held until fetch_done) and byte address
//   fetch_done                 : one-cycle pulse, instruction/fetch_error valid
//   instruction, fetch_error   : result of the last fetch, held until the next fetch_done
//   fetch_count                : number of error-free fetches, wraps
//   m_axi_ar*/m_axi_r*         : AXI read address / read data channels
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [31:0] fetch_address,
  output logic        fetch_done,
  output logic [31:0] instruction,
  output logic        fetch_error,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] fetch_count
);

  // One spare count of headroom: an address handshake landing exactly on the
  // limit leaves the timer at TIMEOUT_CYCLES and it is incremented once more.
  localparam int unsigned   TW          = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);

  fetch_state_e  state_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          timeout_s;
  logic          addr_hs_s;
  logic          data_hs_s;

  logic          fetch_done_q;
  logic [31:0]   instruction_q;
  logic          fetch_error_q;
  logic [31:0]   araddr_q;
  logic          arvalid_q;
  logic          rready_q;
  logic [31:0]   fetch_count_q;

  // Timer next value and bus handshake decode
  always_comb begin
    timer_d   = timer_q + TW'(1);
    timeout_s = (timer_d >= TIMEOUT_LIM);
    addr_hs_s = arvalid_q && m_axi_arready;
    data_hs_s = rready_q && m_axi_rvalid;
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH_IDLE;
      timer_q       <= '0;
      fetch_done_q  <= 1'b0;
      instruction_q <= NOP_INSTR;
      fetch_error_q <= 1'b0;
      araddr_q      <= 32'h0000_0000;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          fetch_done_q <= 1'b0;
          if (fetch_en) begin
            timer_q <= '0;
            if (is_word_aligned(fetch_address)) begin
              araddr_q  <= fetch_address;
              arvalid_q <= 1'b1;
              state_q   <= FETCH_ADDR;
            end else begin
              // No bus access; the pulse is issued from DONE one cycle later.
              instruction_q <= NOP_INSTR;
              fetch_error_q <= 1'b1;
              state_q       <= FETCH_DONE;
            end
          end
        end

        FETCH_ADDR: begin
          // A handshake on the limit cycle still wins: the slave has taken the
          // address, so the read is followed through rather than orphaned.
          if (addr_hs_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            timer_q   <= timer_d;
            state_q   <= FETCH_DATA;
          end else if (timeout_s) begin
            arvalid_q     <= 1'b0;
            instruction_q <= NOP_INSTR;
            fetch_error_q <= 1'b1;
            fetch_done_q  <= 1'b1;
            state_q       <= FETCH_DONE;
          end else begin
            timer_q <= timer_d;
          end
        end

        FETCH_DATA: begin
          if (data_hs_s) begin
            rready_q <= 1'b0;
            if (m_axi_rresp == AXI_RESP_OKAY) begin
              instruction_q <= m_axi_rdata;
              fetch_error_q <= 1'b0;
              fetch_count_q <= fetch_count_q + 32'd1;
            end else begin
              instruction_q <= NOP_INSTR;
              fetch_error_q <= 1'b1;
            end
            fetch_done_q <= 1'b1;
            state_q      <= FETCH_DONE;
          end else if (timeout_s) begin
            rready_q      <= 1'b0;
            instruction_q <= NOP_INSTR;
            fetch_error_q <= 1'b1;
            fetch_done_q  <= 1'b1;
            state_q       <= FETCH_DONE;
          end else begin
            timer_q <= timer_d;
          end
        end

        FETCH_DONE: begin
          // Bus paths arrive with the pulse already raised; the misaligned
          // path arrives without it and raises it here.
          if (fetch_done_q) begin
            fetch_done_q <= 1'b0;
            state_q      <= FETCH_WAIT_LOW;
          end else begin
            fetch_done_q <= 1'b1;
            if (!fetch_error_q) begin
              fetch_count_q <= fetch_count_q + 32'd1;
            end else begin
              fetch_count_q <= fetch_count_q;
            end
          end
        end

        FETCH_WAIT_LOW: begin
          fetch_done_q <= 1'b0;
          if (!fetch_en) begin
            state_q <= FETCH_IDLE;
          end else begin
            state_q <= FETCH_WAIT_LOW;
          end
        end

        default: begin
          state_q      <= FETCH_IDLE;
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          fetch_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_done    = fetch_done_q;
  assign instruction   = instruction_q;
  assign fetch_error   = fetch_error_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (TIMEOUT_CYCLES = 8).
// Latency L means fetch_done is high in cycle N+L, where edge N samples fetch_en.
module tb_instruction_fetch_unit;

  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] fetch_address;
  logic        fetch_done;
  logic [31:0] instruction;
  logic        fetch_error;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_count = 32'd0;

  instruction_fetch_unit #(.TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_address(fetch_address),
    .fetch_done(fetch_done), .instruction(instruction), .fetch_error(fetch_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ar_dly;     // cycles arvalid is held before arready is given
    int          r_dly;      // cycles rready is held before rvalid is given
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          hold;       // extra cycles fetch_en stays high after fetch_done
    bit          drop;       // drop fetch_en mid-transaction
    int          exp_lat;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference: edges are numbered from the sampling edge (0). The address is
  // accepted at edge a = 1+ar_dly, data at edge d = a+1+r_dly. The abort fires
  // once TO edges have elapsed (never before the first DATA edge), a completion
  // on that same edge wins. fetch_done is seen one cycle after the deciding edge.
  function automatic void model(input logic [31:0] addr, input int ar_dly, input int r_dly,
                                input logic [31:0] rdata, input logic [1:0] rresp,
                                output int lat, output logic [31:0] ins, output logic err);
    int a, d, lim;
    a   = 1 + ar_dly;
    d   = a + 1 + r_dly;
    lim = (TO > a + 1) ? TO : a + 1;
    if (addr[1:0] != 2'b00) begin
      lat = 2; ins = NOP; err = 1'b1;
    end else if (a > TO) begin
      lat = TO + 1; ins = NOP; err = 1'b1;
    end else if (d <= lim) begin
      lat = d + 1; ins = (rresp == 2'b00) ? rdata : NOP; err = (rresp != 2'b00);
    end else begin
      lat = lim + 1; ins = NOP; err = 1'b1;
    end
  endfunction

  task automatic run_fetch(input vec_t v, input bit junk, input string nm);
    int   a = -1;
    int   lat = -1;
    int   pulses = 0;
    bit   dtaken = 1'b0;
    bit   addr_ok = 1'b1;
    bit   extra_bus = 1'b0;
    @(negedge clk);
    fetch_en      = 1'b1;
    fetch_address = v.addr;
    for (int k = 0; k < 40; k++) begin
      if (fetch_done) begin
        lat = k;
        pulses = 1;
        break;
      end
      if (m_axi_arvalid && ((m_axi_araddr != v.addr) || (v.addr[1:0] != 2'b00))) addr_ok = 1'b0;
      if (v.drop && k == 2) fetch_en = 1'b0;
      m_axi_arready = (a < 0) && (k >= 1 + v.ar_dly);
      if (a < 0 && m_axi_arvalid && m_axi_arready) a = k;
      if (a >= 0 && !dtaken && k >= a + 1 + v.r_dly) begin
        m_axi_rvalid = 1'b1; m_axi_rdata = v.rdata; m_axi_rresp = v.rresp;
        if (m_axi_rready) dtaken = 1'b1;
      end else if (junk && a < 0) begin
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
      end
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    if (!v.exp_err) exp_count = exp_count + 32'd1;
    chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, " instruction"}, instruction, v.exp_instr);
    chk({nm, " fetch_error"}, {31'd0, fetch_error}, {31'd0, v.exp_err});
    chk({nm, " fetch_count"}, fetch_count, exp_count);
    chk({nm, " bus idle at done"}, {30'd0, m_axi_arvalid, m_axi_rready}, 32'd0);
    chk({nm, " araddr stable/no bus"}, {31'd0, addr_ok}, 32'd1);
    for (int i = 0; i < v.hold + 2; i++) begin
      @(negedge clk);
      if (fetch_done) pulses++;
      if (m_axi_arvalid) extra_bus = 1'b1;
    end
    fetch_en = 1'b0;
    @(negedge clk);
    if (fetch_done) pulses++;
    if (m_axi_arvalid) extra_bus = 1'b1;
    chk({nm, " done pulses"}, 32'(pulses), 32'd1);
    chk({nm, " no refetch"}, {31'd0, extra_bus}, 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t        v;
    int          nrst;
    tbl[0] = '{32'h0000_0100, 0, 0, 32'h0050_0093, 2'b00, 0, 1'b0, 3, 32'h0050_0093, 1'b0};
    tbl[1] = '{32'h0000_0102, 0, 0, 32'h1111_1111, 2'b00, 0, 1'b0, 2, NOP, 1'b1};
    tbl[2] = '{32'h0000_0200, 5, 0, 32'h1234_5678, 2'b10, 0, 1'b0, 8, NOP, 1'b1};
    tbl[3] = '{32'h0000_0300, 99, 0, 32'h2222_2222, 2'b00, 0, 1'b0, 9, NOP, 1'b1};
    tbl[4] = '{32'h0000_0400, 0, 0, 32'hAAAA_5555, 2'b00, 20, 1'b0, 3, 32'hAAAA_5555, 1'b0};
    tbl[5] = '{32'h0000_0500, 1, 2, 32'h0BAD_F00D, 2'b00, 0, 1'b1, 6, 32'h0BAD_F00D, 1'b0};
    tbl[6] = '{32'h0000_0600, 2, 99, 32'h3333_3333, 2'b00, 0, 1'b0, 9, NOP, 1'b1};
    tbl[7] = '{32'h0000_0700, 6, 1, 32'h4444_4444, 2'b00, 1, 1'b0, 9, NOP, 1'b1};

    reset = 1'b1; fetch_en = 1'b0; fetch_address = 32'd0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset instruction", instruction, NOP);
    chk("reset outputs", {28'd0, fetch_done, fetch_error, m_axi_arvalid, m_axi_rready}, 32'd0);
    chk("reset araddr", m_axi_araddr, 32'd0);
    chk("reset count", fetch_count, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_fetch(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset while waiting in DATA: the read is abandoned without a pulse.
    @(negedge clk);
    fetch_en = 1'b1; fetch_address = 32'h0000_0800; m_axi_arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_axi_arready = 1'b0;
    chk("rst_mid rready before reset", {31'd0, m_axi_rready}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid bus dropped", {29'd0, m_axi_arvalid, m_axi_rready, fetch_done}, 32'd0);
    chk("rst_mid araddr", m_axi_araddr, 32'd0);
    chk("rst_mid count", fetch_count, 32'd0);
    chk("rst_mid instruction", instruction, NOP);
    exp_count = 32'd0;
    fetch_en = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b0;
    nrst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fetch_done) nrst++;
    end
    m_axi_rvalid = 1'b0;
    chk("rst_mid no done", 32'(nrst), 32'd0);
    run_fetch(tbl[0], 1'b0, "post_reset");

    // Randomized fetches against the reference model.
    for (int i = 0; i < 30; i++) begin
      v.addr = $urandom();
      if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
      v.ar_dly = $urandom_range(0, 4);
      v.r_dly  = $urandom_range(0, 4);
      v.rdata  = $urandom();
      v.rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.hold   = $urandom_range(0, 2);
      v.drop   = 1'($urandom_range(0, 1));
      model(v.addr, v.ar_dly, v.r_dly, v.rdata, v.rresp, v.exp_lat, v.exp_instr, v.exp_err);
      run_fetch(v, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles from bus request to read data before abort.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, instruction returned on any error.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  fetch request from control_unit, level, held until fetch_done.
REQ-006 fetch_address  input  32  byte address of instruction, valid while fetch_en high.
REQ-007 fetch_done  output  1  one-cycle pulse: instruction and fetch_error valid.
REQ-008 instruction  output  32  fetched instruction, held until next fetch_done.
REQ-009 fetch_error  output  1  error status of last fetch, held with instruction.
REQ-010 m_axi_araddr  output  32  read address to instruction memory.
REQ-011 m_axi_arvalid  output  1  read address valid.
REQ-012 m_axi_arready  input  1  read address accepted.
REQ-013 m_axi_rdata  input  32  read data.
REQ-014 m_axi_rresp  input  2  read response; nonzero = error.
REQ-015 m_axi_rvalid  input  1  read data valid.
REQ-016 m_axi_rready  output  1  read data ready.
REQ-017 fetch_count  output  32  count of successful (error-free) fetches, wraps at 2^32.

Function
REQ-018 FSM states IDLE, ADDR, DATA, DONE, WAIT_LOW; all outputs registered.
REQ-019 IDLE: fetch_en high with fetch_address[1:0]==0 -> capture address into m_axi_araddr, go ADDR.
REQ-020 IDLE: fetch_en high with fetch_address[1:0]!=0 -> no bus transaction, instruction=NOP_INSTR, fetch_error=1, go DONE.
REQ-021 ADDR: m_axi_arvalid=1 and m_axi_araddr stable until m_axi_arvalid&&m_axi_arready, then go DATA.
REQ-022 DATA: m_axi_rready=1; on m_axi_rvalid capture rdata into instruction, fetch_error=(rresp!=0), go DONE.
REQ-023 On rresp!=0, instruction=NOP_INSTR instead of rdata.
REQ-024 Timeout counter cleared on leaving IDLE, increments each cycle in ADDR/DATA; reaching TIMEOUT_CYCLES -> arvalid/rready drop, instruction=NOP_INSTR, fetch_error=1, go DONE.
REQ-025 DONE: fetch_done=1 for exactly one cycle; fetch_count increments if fetch_error==0; go WAIT_LOW.
REQ-026 WAIT_LOW: stay until fetch_en==0, then IDLE; a held fetch_en never starts a second fetch.
REQ-027 Minimum latency: fetch_en sampled at edge N, arvalid from N+1, arready and rvalid at first opportunity -> fetch_done high in cycle N+3.
REQ-028 fetch_en dropping mid-transaction does not abort; the transaction completes and fetch_done pulses.
REQ-029 m_axi_rvalid outside DATA is ignored (rready low).

Reset
REQ-030 reset asserted: state=IDLE, m_axi_arvalid=0, m_axi_rready=0, fetch_done=0, fetch_error=0, instruction=NOP_INSTR, m_axi_araddr=0, fetch_count=0, timeout counter=0, immediately and asynchronously.
REQ-031 reset mid-transaction abandons it; no fetch_done is produced for it.

Structure
REQ-032 Shared package cpu_pkg holds NOP_INSTR constant, AXI response codes (OKAY=2'b00), and fetch state typedef.
REQ-033 Single flat module; no sub-module needed.

Verification
REQ-034 Aligned fetch 0x00000100, arready/rvalid immediate, rdata=0x00500093, rresp=0 -> fetch_done at N+3, instruction=0x00500093, fetch_error=0, fetch_count=1.
REQ-035 Misaligned fetch 0x00000102 -> no arvalid, fetch_done at N+2, instruction=0x00000013, fetch_error=1, fetch_count unchanged.
REQ-036 arready delayed 5 cycles, rresp=2'b10 -> araddr stable throughout, instruction=0x00000013, fetch_error=1.
REQ-037 TIMEOUT_CYCLES=8, memory never answers -> arvalid drops, fetch_done with fetch_error=1 eight cycles after leaving IDLE.
REQ-038 fetch_en held high for 20 cycles after fetch_done -> exactly one fetch_done; new fetch only after fetch_en low one cycle.
REQ-039 reset pulsed while in DATA -> arvalid/rready low same cycle, no fetch_done, next fetch completes normally.
